bus_master_arbiter: RTL

- Arbitrates the shared system-bus slave path between the three request/grant bus masters: SPI slave, PIM DMA and core data port. The core instruction port is not arbitrated.
- Produces a registered one-hot grant and an encoded owner select, which the bus uses to steer its address, data and control muxes.
- Policy is fixed priority with anti-starvation aging, plus optional bounded-hold preemption for masters that are not locked.

---
 rtl/bus_arb_pkg.sv | 24 ++
 rtl/arb_age_cnt.sv | 19 +
 rtl/bus_master_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the system-bus master arbiter.
package bus_arb_pkg;
  localparam int NUM_MST  = 3;
  localparam int MST_SPI  = 0;
  localparam int MST_DMA  = 1;
  localparam int MST_DMEM = 2;
  localparam logic [1:0] OWNER_NONE = 2'd3;

  typedef enum logic [1:0] {IDLE, OWNED, DRAIN} arb_state_e;

  function automatic logic [1:0] onehot_to_owner(input logic [NUM_MST-1:0] oh);
    logic [1:0] o;
    o = OWNER_NONE;
    if (oh[MST_SPI])       o = 2'(MST_SPI);
    else if (oh[MST_DMA])  o = 2'(MST_DMA);
    else if (oh[MST_DMEM]) o = 2'(MST_DMEM);
    return o;
  endfunction

  // Lowest set bit wins: SPI > DMA > DMEM.
  function automatic logic [NUM_MST-1:0] prio_pick(input logic [NUM_MST-1:0] v);
    return v & (~v + NUM_MST'(1));
  endfunction
endpackage

// File: rtl/arb_age_cnt.sv
// Per-master saturating wait counter; flags a requester that has waited long enough.
module arb_age_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       gnt,
  input  logic [7:0] limit,
  output logic       aged
);
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt <= '0;
    else if (!req || gnt)   cnt <= '0;
    else if (cnt < limit)   cnt <= cnt + 8'd1;
  end

  assign aged = (cnt >= limit);
endmodule

// File: rtl/bus_master_arbiter.sv
// Fixed-priority bus arbiter with aging and bounded-hold preemption of unlocked owners.
module bus_master_arbiter
  import bus_arb_pkg::*;
#(
  parameter int AGE_LIMIT = 64,
  parameter int MAX_HOLD  = 1024,
  parameter int HOLD_W    = $clog2(MAX_HOLD+1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [2:0]   req_i,
  input  logic [2:0]   lock_i,
  output logic [2:0]   gnt_o,
  output logic [1:0]   owner_o,
  output logic         busy_o,
  output logic         preempt_o
);
  localparam int HW = (HOLD_W < 1) ? 1 : HOLD_W;
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);
  localparam logic [7:0] AGE_LIM8 = 8'(AGE_LIMIT);
  localparam bit PREEMPT_EN = (MAX_HOLD != 0);

  arb_state_e           state_q, state_d;
  logic [NUM_MST-1:0]   gnt_q, gnt_d;
  logic [NUM_MST-1:0]   excl_q, excl_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 preempt_q, preempt_d;
  logic [NUM_MST-1:0]   aged, elig, aged_req, win;
  logic                 owned_req, hold_sat, preempt_hit;

  for (genvar m = 0; m < NUM_MST; m++) begin : g_age
    arb_age_cnt u_age (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .req   (req_i[m]),
      .gnt   (gnt_q[m]),
      .limit (AGE_LIM8),
      .aged  (aged[m])
    );
  end

  always_comb begin
    owned_req   = |(req_i & gnt_q);
    // After a preemption the revoked owner sits out one arbitration round.
    elig        = (state_q == DRAIN) ? (req_i & ~excl_q) : req_i;
    aged_req    = elig & aged;
    win         = (|aged_req) ? prio_pick(aged_req) : prio_pick(elig);
    hold_sat    = (hold_q == HOLD_LAST);
    preempt_hit = PREEMPT_EN && hold_sat && !(|(lock_i & gnt_q)) && (|(req_i & ~gnt_q));

    state_d   = state_q;
    gnt_d     = gnt_q;
    excl_d    = excl_q;
    preempt_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          gnt_d   = win;
          state_d = OWNED;
        end
      end
      OWNED: begin
        if (!owned_req) begin
          gnt_d   = win;
          state_d = (|elig) ? OWNED : IDLE;
        end else if (preempt_hit) begin
          gnt_d     = '0;
          excl_d    = gnt_q;
          preempt_d = 1'b1;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        gnt_d   = win;
        excl_d  = '0;
        state_d = (|elig) ? OWNED : IDLE;
      end
      default: begin
        gnt_d   = '0;
        excl_d  = '0;
        state_d = IDLE;
      end
    endcase

    if ((gnt_d != gnt_q) || (state_d != OWNED)) hold_d = '0;
    else if (!hold_sat)                         hold_d = hold_q + HW'(1);
    else                                        hold_d = hold_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      excl_q    <= '0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      excl_q    <= excl_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign owner_o   = onehot_to_owner(gnt_q);
  assign busy_o    = |gnt_q;
  assign preempt_o = preempt_q;
endmodule
